// File: rtl/rv_mc_datapath_bus.sv
// rv_mc_datapath_bus
// Multi-cycle RISC-V datapath with a valid/ready memory bus port.
// It supports sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW).
// The register file depth is selectable: NREGS=32 for RV32I, NREGS=16 for RV32E.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   pc_write, reg_write      PC load enable, register file write enable
//   adr_src                  memory address select (0=PC, 1=Result)
//   mem_req                  start a bus transaction (accepted only in IDLE)
//   mem_we, ir_write         transaction is a store / an instruction fetch
//   result_src               Result mux: ALUOut/LoadData/ALUResult/ImmExt
//   alu_src_a                SrcA mux: PC/OldPC/A/0
//   alu_src_b                SrcB mux: B/ImmExt/4/0
//   alu_control, imm_src     ALU operation, immediate format
//   op, func3, func7         IR fields [6:0], [14:12], [30]
//   zero, neg                ALU flags (combinational)
//   mem_done, mem_err        completion pulse / misaligned-reject pulse
//   bus_*                    memory bus (word-aligned address, byte strobes)
module rv_mc_datapath_bus #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        reg_write,
  input  logic        adr_src,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic        ir_write,
  input  logic [1:0]  result_src,
  input  logic [1:0]  alu_src_a,
  input  logic [1:0]  alu_src_b,
  input  logic [2:0]  alu_control,
  input  logic [2:0]  imm_src,
  output logic [6:0]  op,
  output logic [2:0]  func3,
  output logic        func7,
  output logic        zero,
  output logic        neg,
  output logic        mem_done,
  output logic        mem_err,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  // Register index width; upper index bits of rs1/rs2/rd are ignored for RV32E.
  localparam int RW = (NREGS == 16) ? 4 : 5;

  typedef enum logic [1:0] {IDLE, REQ, DONE} bus_state_e;

  bus_state_e  state_q, state_d;

  logic [31:0] pc_q, oldpc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
  logic [31:0] rf_q [NREGS];

  // Latched transaction info
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  off_q;
  logic        we_q, fetch_q, err_q;

  logic [31:0] imm_ext, src_a, src_b, alu_result, load_data, result, adr;
  logic [31:0] mdr_sh, wdata_d;
  logic [3:0]  wstrb_d;
  logic [1:0]  size;
  logic        misaligned, req_acc, err_d, capture;

  // ---------------- immediate generation ----------------
  always_comb begin
    case (imm_src)
      3'd1:    imm_ext = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};                  // S
      3'd2:    imm_ext = {{20{ir_q[31]}}, ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};   // B
      3'd3:    imm_ext = {{12{ir_q[31]}}, ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0}; // J
      3'd4:    imm_ext = {ir_q[31:12], 12'b0};                                       // U
      default: imm_ext = {{20{ir_q[31]}}, ir_q[31:20]};                              // I
    endcase
  end

  // ---------------- ALU ----------------
  always_comb begin
    case (alu_src_a)
      2'd0:    src_a = pc_q;
      2'd1:    src_a = oldpc_q;
      2'd2:    src_a = a_q;
      default: src_a = '0;
    endcase
    case (alu_src_b)
      2'd0:    src_b = b_q;
      2'd1:    src_b = imm_ext;
      2'd2:    src_b = 32'd4;
      default: src_b = '0;
    endcase
    case (alu_control)
      3'd0:    alu_result = src_a + src_b;
      3'd1:    alu_result = src_a - src_b;
      3'd2:    alu_result = src_a & src_b;
      3'd3:    alu_result = src_a | src_b;
      3'd4:    alu_result = src_a ^ src_b;
      3'd5:    alu_result = {31'b0, $signed(src_a) < $signed(src_b)};
      3'd6:    alu_result = src_a << src_b[4:0];
      default: alu_result = src_a >> src_b[4:0];
    endcase
  end

  assign zero = (alu_result == '0);
  assign neg  = alu_result[31];

  // ---------------- load extraction ----------------
  // The lane offset comes from the latched address; the extension comes from the current IR.
  assign mdr_sh = mdr_q >> {off_q, 3'b000};

  always_comb begin
    case (ir_q[14:12])
      3'b000:  load_data = {{24{mdr_sh[7]}}, mdr_sh[7:0]};
      3'b001:  load_data = {{16{mdr_sh[15]}}, mdr_sh[15:0]};
      3'b100:  load_data = {24'b0, mdr_sh[7:0]};
      3'b101:  load_data = {16'b0, mdr_sh[15:0]};
      default: load_data = mdr_q;
    endcase
  end

  always_comb begin
    case (result_src)
      2'd0:    result = aluout_q;
      2'd1:    result = load_data;
      2'd2:    result = alu_result;
      default: result = imm_ext;
    endcase
  end

  assign adr = adr_src ? result : pc_q;

  // ---------------- request decode ----------------
  // Fetches are always word-sized. Data accesses take their size from func3[1:0];
  // a size code of 2'b11 is treated as a word.
  assign size       = ir_write ? 2'b10 : ir_q[13:12];
  assign misaligned = (size == 2'b01 && adr[0]) || (size[1] && adr[1:0] != 2'b00);

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = b_q;
    case (size)
      2'b00: begin
        wstrb_d = 4'b0001 << adr[1:0];
        wdata_d = {4{b_q[7:0]}};
      end
      2'b01: begin
        wstrb_d = 4'b0011 << adr[1:0];
        wdata_d = {2{b_q[15:0]}};
      end
      default: wstrb_d = 4'b1111;
    endcase
    if (!mem_we) wstrb_d = 4'b0000;
  end

  // ---------------- bus FSM ----------------
  always_comb begin
    state_d = state_q;
    req_acc = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (mem_req) begin
        if (misaligned) err_d = 1'b1;
        else begin
          state_d = REQ;
          req_acc = 1'b1;
        end
      end
      REQ:     if (bus_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign capture = (state_q == REQ) && bus_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (req_acc) begin
        addr_q  <= {adr[31:2], 2'b00};
        off_q   <= adr[1:0];
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        we_q    <= mem_we;
        fetch_q <= ir_write;
      end
    end
  end

  assign bus_valid = (state_q == REQ);
  assign bus_we    = bus_valid & we_q;
  assign bus_wstrb = bus_valid ? wstrb_q : 4'b0000;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign mem_done  = (state_q == DONE);
  assign mem_err   = err_q;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      oldpc_q  <= '0;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      a_q      <= rf_q[ir_q[15 +: RW]];
      b_q      <= rf_q[ir_q[20 +: RW]];
      aluout_q <= alu_result;
      if (pc_write) pc_q <= result;
      if (capture && !we_q) mdr_q <= bus_rdata;
      if (capture && fetch_q) begin
        ir_q    <= bus_rdata;
        oldpc_q <= pc_q;
      end
    end
  end

  // Entry 0 is never written, so reads of x0 return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (reg_write && ir_q[7 +: RW] != '0) begin
      rf_q[ir_q[7 +: RW]] <= result;
    end
  end

  assign op    = ir_q[6:0];
  assign func3 = ir_q[14:12];
  assign func7 = ir_q[30];

endmodule

// File: tb/tb_rv_mc_datapath_bus.sv
// Testbench for rv_mc_datapath_bus in its RV32E configuration.
// The bench drives the controller inputs directly and plays the memory side of the bus.
// Register contents are observed by storing them through the bus write data.
module tb_rv_mc_datapath_bus;
  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, reg_write, adr_src, mem_req, mem_we, ir_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b;
  logic [2:0]  alu_control, imm_src;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic        func7, zero, neg, mem_done, mem_err;
  logic        bus_valid, bus_we, bus_ready;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  int vectors = 0;
  int errs    = 0;

  logic [31:0] pc_m;
  logic [31:0] rf_m [16];

  rv_mc_datapath_bus #(.RESET_PC(RPC), .NREGS(16)) dut (
    .clk(clk), .rst(rst),
    .pc_write(pc_write), .reg_write(reg_write), .adr_src(adr_src),
    .mem_req(mem_req), .mem_we(mem_we), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src),
    .op(op), .func3(func3), .func7(func7), .zero(zero), .neg(neg),
    .mem_done(mem_done), .mem_err(mem_err),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic clear_ctl();
    pc_write = 0; reg_write = 0; adr_src = 0; mem_we = 0; ir_write = 0;
    result_src = 0; alu_src_a = 0; alu_src_b = 0; alu_control = 0; imm_src = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] w, input int off);
    longint v;
    case (f3)
      3'b000, 3'b100: v = longint'((w >> (8 * off)) & 32'hFF);
      3'b001, 3'b101: v = longint'((w >> (8 * off)) & 32'hFFFF);
      default: return w;
    endcase
    if (f3 == 3'b000 && v >= 128)   v -= 256;
    if (f3 == 3'b001 && v >= 32768) v -= 65536;
    return 32'(v);
  endfunction

  function automatic logic [3:0] st_strb(input logic [2:0] f3, input int off);
    return 4'(((1 << nbytes(f3)) - 1) << off);
  endfunction

  function automatic logic [31:0] st_data(input logic [2:0] f3, input logic [31:0] b);
    logic [31:0] r;
    int n;
    n = nbytes(f3);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[8*(i % n) +: 8];
    return r;
  endfunction

  // Drives mem_req with the control inputs already set by the caller, then plays the memory
  // with 'waits' not-ready cycles. It returns in the IDLE cycle that follows DONE.
  task automatic run_bus(input logic [31:0] rdata, input int waits, input logic [31:0] ea,
                         input logic ewe, input logic [3:0] es, input logic [31:0] ew, input bit fetch);
    mem_req = 1; bus_ready = 0;
    tick();
    mem_req = 0;
    clear_ctl();
    for (int n = 0; n <= waits; n++) begin
      bus_ready = (n == waits);
      bus_rdata = (n == waits) ? rdata : $urandom;
      chk1("bus_valid", bus_valid, 1'b1);
      chk("bus_addr", bus_addr, ea);
      chk1("bus_we", bus_we, ewe);
      chk({28'b0, bus_wstrb} === {28'b0, es} ? "bus_wstrb" : "bus_wstrb", {28'b0, bus_wstrb}, {28'b0, es});
      if (ewe) chk("bus_wdata", bus_wdata, ew);
      chk1("mem_done_early", mem_done, 1'b0);
      tick();
    end
    bus_ready = 0;
    chk1("mem_done", mem_done, 1'b1);
    chk1("valid_in_done", bus_valid, 1'b0);
    if (fetch) begin
      chk("op", {25'b0, op}, {25'b0, rdata[6:0]});
      chk("func3", {29'b0, func3}, {29'b0, rdata[14:12]});
      chk1("func7", func7, rdata[30]);
    end
    tick();
    chk1("mem_done_clear", mem_done, 1'b0);
  endtask

  // A misaligned request must pulse mem_err for one cycle and leave the bus untouched.
  task automatic run_err();
    mem_req = 1; bus_ready = 1;
    tick();
    mem_req = 0;
    clear_ctl();
    chk1("mem_err", mem_err, 1'b1);
    chk1("err_valid", bus_valid, 1'b0);
    tick();
    chk1("mem_err_clear", mem_err, 1'b0);
    chk1("err_valid2", bus_valid, 1'b0);
    chk1("err_done", mem_done, 1'b0);
    bus_ready = 0;
  endtask

  task automatic fetch(input logic [31:0] instr, input int waits);
    clear_ctl();
    ir_write = 1;
    run_bus(instr, waits, pc_m, 1'b0, 4'b0, 32'b0, 1'b1);
  endtask

  // Fetches a load with I-immediate 'a', loads 'rdata' from address a, and writes LoadData to rd.
  task automatic load_to_reg(input logic [4:0] rd, input logic [2:0] f3, input logic [11:0] a,
                             input logic [31:0] rdata, input int waits);
    fetch({a, 5'd0, f3, rd, 7'b0000011}, 0);
    adr_src = 1; result_src = 2'b11; imm_src = 3'd0;
    run_bus(rdata, waits, {20'b0, a[11:2], 2'b00}, 1'b0, 4'b0, 32'b0, 1'b0);
    result_src = 2'b01; reg_write = 1;
    tick();
    clear_ctl();
    if (rd[3:0] != 4'd0) rf_m[rd[3:0]] = ld_model(f3, rdata, int'(a[1:0]));
  endtask

  task automatic write_reg(input logic [4:0] rd, input logic [31:0] v);
    load_to_reg(rd, 3'b010, 12'h000, v, 0);
  endtask

  // Reads a register by storing it word-wide: bus_wdata must equal the register.
  task automatic read_reg(input logic [4:0] rs2, input logic [31:0] exp);
    fetch({7'd0, rs2, 5'd0, 3'b010, 5'd0, 7'b0100011}, 0);
    mem_we = 1; adr_src = 1; result_src = 2'b11; imm_src = 3'd1;
    run_bus($urandom, 0, 32'h0, 1'b1, 4'hF, exp, 1'b0);
  endtask

  task automatic store_chk(input logic [4:0] rs2, input logic [2:0] f3, input logic [11:0] a,
                           input logic [3:0] es, input logic [31:0] ew, input bit err, input int waits);
    fetch({a[11:5], rs2, 5'd0, f3, a[4:0], 7'b0100011}, 0);
    mem_we = 1; adr_src = 1; result_src = 2'b11; imm_src = 3'd1;
    if (err) run_err();
    else     run_bus($urandom, waits, {20'b0, a[11:2], 2'b00}, 1'b1, es, ew, 1'b0);
  endtask

  logic [4:0]  r;
  logic [2:0]  f3;
  logic [31:0] d;
  int          off, w;
  logic [2:0]  ld_ops [5];

  initial begin
    ld_ops[0] = 3'b000; ld_ops[1] = 3'b001; ld_ops[2] = 3'b010; ld_ops[3] = 3'b100; ld_ops[4] = 3'b101;
    rst = 0; mem_req = 0; bus_ready = 0; bus_rdata = 0;
    clear_ctl();
    pc_m = RPC;
    for (int i = 0; i < 16; i++) rf_m[i] = 0;
    tick(); tick();

    // Reset state
    chk1("rst_valid", bus_valid, 1'b0);
    chk1("rst_done", mem_done, 1'b0);
    chk1("rst_err", mem_err, 1'b0);
    chk1("rst_we", bus_we, 1'b0);
    chk("rst_wstrb", {28'b0, bus_wstrb}, 32'h0);
    chk("rst_op", {25'b0, op}, 32'h0);
    rst = 1;
    tick();

    // Zero-wait fetch
    fetch(32'h0050_0093, 0);
    chk("op_addi", {25'b0, op}, 32'h13);

    // Flags: 0+0 gives zero; 0-4 gives a negative result
    alu_src_a = 2'd3; alu_src_b = 2'd3; alu_control = 3'd0; #1;
    chk1("zero_flag", zero, 1'b1);
    chk1("neg_flag0", neg, 1'b0);
    alu_src_b = 2'd2; alu_control = 3'd1; #1;
    chk1("zero_flag1", zero, 1'b0);
    chk1("neg_flag1", neg, 1'b1);
    clear_ctl();

    // OldPC observed as a data address (the fetched addi has byte size)
    alu_src_a = 2'd1; alu_src_b = 2'd3; result_src = 2'd2; adr_src = 1;
    run_bus($urandom, 0, RPC, 1'b0, 4'b0, 32'b0, 1'b0);

    // pc_write in the request cycle: the fetch address is the pre-edge PC
    ir_write = 1; pc_write = 1; result_src = 2'd2; alu_src_a = 2'd0; alu_src_b = 2'd2;
    run_bus(32'h0000_0013, 0, pc_m, 1'b0, 4'b0, 32'b0, 1'b1);
    pc_m = pc_m + 4;
    fetch(32'h0000_0013, 0);

    // Fetch with wait states; only the final beat may land in IR
    fetch(32'h4000_5033, 3);

    // Sub-word loads from 32'h80FF_7F01 at offset 2
    load_to_reg(5'd5, 3'b000, 12'h102, 32'h80FF_7F01, 0);
    read_reg(5'd5, 32'hFFFF_FFFF);
    load_to_reg(5'd5, 3'b100, 12'h102, 32'h80FF_7F01, 1);
    read_reg(5'd5, 32'h0000_00FF);
    load_to_reg(5'd5, 3'b001, 12'h102, 32'h80FF_7F01, 0);
    read_reg(5'd5, 32'hFFFF_80FF);

    // Stores: SB at offset 3, a waited SW, and SH at offset 1 (rejected)
    write_reg(5'd7, 32'h0000_00AB);
    store_chk(5'd7, 3'b000, 12'h103, 4'b1000, 32'hABAB_ABAB, 1'b0, 0);
    write_reg(5'd8, 32'h1357_9BDF);
    store_chk(5'd8, 3'b010, 12'h204, 4'b1111, 32'h1357_9BDF, 1'b0, 3);
    store_chk(5'd8, 3'b001, 12'h101, 4'b0000, 32'h0, 1'b1, 0);

    // RV32E aliasing and x0
    write_reg(5'd3, 32'h0000_1234);
    read_reg(5'd3, 32'h0000_1234);
    write_reg(5'd19, 32'hCAFE_F00D);
    read_reg(5'd3, 32'hCAFE_F00D);
    read_reg(5'd19, 32'hCAFE_F00D);
    write_reg(5'd0, 32'hFFFF_FFFF);
    read_reg(5'd0, 32'h0);

    // Randomized loads and stores against the model
    for (int it = 0; it < 16; it++) begin
      r   = 5'($urandom_range(1, 31));
      f3  = ld_ops[$urandom_range(0, 4)];
      off = ($urandom_range(0, 3) / nbytes(f3)) * nbytes(f3);
      d   = $urandom;
      w   = $urandom_range(0, 3);
      load_to_reg(r, f3, 12'((($urandom_range(0, 500)) << 2) | off), d, w);
      read_reg(r, rf_m[r[3:0]]);

      r   = 5'($urandom_range(1, 15));
      d   = $urandom;
      write_reg(r, d);
      f3  = 3'($urandom_range(0, 2));
      off = $urandom_range(0, 3);
      store_chk(r, f3, 12'((($urandom_range(0, 500)) << 2) | off), st_strb(f3, off),
                st_data(f3, rf_m[r[3:0]]), (off % nbytes(f3)) != 0, $urandom_range(0, 2));
    end

    // Reset in the middle of a request
    clear_ctl();
    ir_write = 1; mem_req = 1; bus_ready = 0;
    tick();
    mem_req = 0; clear_ctl();
    chk1("midreq_valid", bus_valid, 1'b1);
    #2 rst = 0;
    #1 chk1("async_drop", bus_valid, 1'b0);
    tick();
    rst = 1;
    bus_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1("no_done_after_rst", mem_done, 1'b0);
      chk1("no_valid_after_rst", bus_valid, 1'b0);
    end
    bus_ready = 0;
    pc_m = RPC;
    for (int i = 0; i < 16; i++) rf_m[i] = 0;
    fetch(32'h0000_0013, 0);
    read_reg(5'd8, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/rv_mc_datapath_bus.md
# rv_mc_datapath_bus

Parametrised multi-cycle RISC-V datapath that replaces the single-cycle combinational memory port with an external valid/ready memory bus. It adds sub-word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) and a configurable register-file depth (RV32I or RV32E). It sits between the multi-cycle controller, which drives all datapath control inputs and waits on `mem_done`/`mem_err`, and the system memory or interconnect.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value on reset.
- `NREGS`, 32: register count, 32 or 16 (RV32E); unused upper index bits ignored, x0 hardwired to 0.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `pc_write, reg_write, adr_src`  in  1 each  PC load enable, RF write enable, address select (0=PC, 1=Result).
- `mem_req`  in  1  start bus transaction (sampled only in IDLE).
- `mem_we`  in  1  transaction is a store (latched with `mem_req`).
- `ir_write`  in  1  transaction is an instruction fetch (latched with `mem_req`).
- `result_src, alu_src_a, alu_src_b`  in  2 each  mux selects (Result: ALUOut/LoadData/ALUResult/ImmExt; A: PC/OldPC/A/0; B: B/ImmExt/4/0).
- `alu_control, imm_src`  in  3 each  ALU op, immediate format.
- `op`  out 7, `func3`  out 3, `func7`  out 1  IR fields [6:0], [14:12], [30].
- `zero, neg`  out 1 each  ALU flags (combinational).
- `mem_done`  out 1  one-cycle pulse: transaction complete.
- `mem_err`  out 1  one-cycle pulse: misaligned request rejected.
- `bus_valid`  out 1, `bus_we` out 1, `bus_addr` out 32 (word-aligned, [1:0]=0), `bus_wdata` out 32, `bus_wstrb` out 4.
- `bus_ready`  in 1, `bus_rdata` in 32.

## Operation
- Bus FSM states IDLE, REQ, DONE.
  - IDLE: on `mem_req`, latch Adr, `mem_we`, `ir_write`, lane info; go to REQ, or, if misaligned, pulse `mem_err` and stay in IDLE.
  - REQ: `bus_valid`=1, with all bus outputs held stable until `bus_ready`=1 is sampled. Then capture `bus_rdata` into MDR (loads and fetches) and into IR, with PC into OldPC, if it is a fetch. Go to DONE.
  - DONE: `mem_done`=1 for one cycle, then return to IDLE.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0. Fetches are always word-sized. The size comes from the latched `func3[1:0]` for data accesses.
- Stores:
  - `bus_wdata` = B replicated: byte into all 4 lanes, half into both halves.
  - `bus_wstrb`: SB → 4'b0001<<addr[1:0]; SH → 4'b0011<<addr[1:0]; SW → 4'b1111.
  - Fetch and load strobes are 4'b0000.
- Load path: LoadData = MDR lane selected by the latched addr[1:0], sign- or zero-extended per IR `func3` (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; others treated as LW).
- A, B and ALUOut registers load every cycle. PC loads Result on `pc_write`. RF writes Result to rd on `reg_write` at the clock edge; writes to x0 are dropped.
- `mem_req` outside IDLE is ignored. `pc_write` in the same cycle as `mem_req`: address latched from pre-edge PC.

## Timing
- Reset (async, `rst`=0):
  - PC=`RESET_PC`.
  - IR, OldPC, MDR, A, B, ALUOut and all RF entries = 0.
  - FSM=IDLE; `bus_valid`, `mem_done`, `mem_err`, `bus_we`=0; `bus_wstrb`=0.
- Reset during REQ drops `bus_valid` immediately; the transaction is abandoned and nothing is captured.
- Latency: `mem_req` at edge t → `bus_valid` high in cycle t+1. With N wait cycles (`bus_ready` low for N cycles), capture happens at edge t+1+N and `mem_done` is high in cycle t+2+N. Zero-wait gives `mem_done` 2 cycles after `mem_req`.
- `mem_err` is high in cycle t+1; no bus activity.
- IR, `op`, `func3` and `func7` reflect a new fetch in the `mem_done` cycle.

## Test plan
- Zero-wait fetch: reset, `mem_req`+`ir_write` with `bus_ready`=1, `bus_rdata`=32'h00500093 → `bus_addr`=`RESET_PC`, `mem_done` 2 cycles later, `op`=7'h13, OldPC=`RESET_PC`.
- Wait states: `bus_ready` low for 3 cycles → `bus_valid`, `bus_addr`, `bus_wdata` and `bus_wstrb` stable throughout; `mem_done` at cycle 5; single capture.
- Sub-word load: `bus_rdata`=32'h80FF_7F01, addr offset 2, LB → Result 32'hFFFF_FFFF; LBU → 32'h0000_00FF; LH offset 2 → 32'hFFFF_80FF.
- Stores:
  - SB with B=32'h0000_00AB at offset 3 → `bus_wstrb`=4'b1000, `bus_wdata`=32'hABAB_ABAB.
  - SH at offset 1 → `mem_err` pulse, `bus_valid` never rises.
- RV32E (`NREGS`=16): write x3=32'h1234 and x19 (aliases x3) → read back matches the last write; writing x0 reads 0.
- Reset mid-REQ: assert `rst`=0 while `bus_valid`=1 → `bus_valid` falls asynchronously, PC=`RESET_PC`, no `mem_done` after release.
